seq_divider4: RTL



---
 rtl/seq_divider4_if.sv | 25 ++
 rtl/seq_divider4.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seq_divider4_if.sv
// Start/done handshake and operand/result bus between a controller and the divider.
interface seq_divider4_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Controller side: issues requests and reads results
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side: accepts requests and produces results
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider4.sv
// Sequential restoring divider: one quotient bit per clock, built on a single
// trial subtraction (add inverted divisor with carry-in 1; carry-out 1 = no borrow).
module seq_divider4 #(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          rst,
  seq_divider4_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH+1:0] CARRY_IN = {{(WIDTH+1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH:0]   accum_q, accum_d;
  logic [WIDTH-1:0] shiftQ_q, shiftQ_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] divisorReg_q, divisorReg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             divZero_q, divZero_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shiftedRem;
  logic [WIDTH+1:0] trial;
  logic             noBorrow;
  logic [WIDTH:0]   accumStep;
  logic [WIDTH-1:0] shiftQStep;
  logic             lastStep;
  logic             busyOut;
  logic             unusedAccumTop;

  // The accumulator top bit is always zero after a step because the partial
  // remainder stays below the divisor; it only widens the trial subtraction.
  assign unusedAccumTop = accum_q[WIDTH];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: zero divisor skips straight to FIN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = (bus.divisor != '0) ? CALC : FIN;
      CALC: if (lastStep)  state_d = FIN;
      FIN:                 state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Output logic: busy only while iterating
  always_comb begin
    busyOut = (state_q == CALC);
  end

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore
  always_comb begin
    shiftedRem = {accum_q[WIDTH-1:0], shiftQ_q[WIDTH-1]};
    trial      = {1'b0, shiftedRem} + {1'b0, ~{1'b0, divisorReg_q}} + CARRY_IN;
    noBorrow   = trial[WIDTH+1];
    accumStep  = noBorrow ? trial[WIDTH:0] : shiftedRem;
    shiftQStep = {shiftQ_q[WIDTH-2:0], noBorrow};
    lastStep   = (count_q == CNT_LAST);
  end

  // Datapath next values: capture on accepted start, iterate in CALC, publish on entry to FIN
  always_comb begin
    accum_d      = accum_q;
    shiftQ_d     = shiftQ_q;
    count_d      = count_q;
    divisorReg_d = divisorReg_q;
    quotient_d   = quotient_q;
    remainder_d  = remainder_q;
    divZero_d    = divZero_q;
    done_d       = (state_q == FIN);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          divisorReg_d = bus.divisor;
          count_d      = '0;
          accum_d      = '0;
          shiftQ_d     = bus.dividend;
          if (bus.divisor == '0) begin
            quotient_d  = '1;
            remainder_d = bus.dividend;
            divZero_d   = 1'b1;
          end
        end
      end
      CALC: begin
        accum_d  = accumStep;
        shiftQ_d = shiftQStep;
        count_d  = count_q + CNT_ONE;
        if (lastStep) begin
          quotient_d  = shiftQStep;
          remainder_d = accumStep[WIDTH-1:0];
          divZero_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any in-flight operation and clears results
  always_ff @(posedge clk) begin
    if (rst) begin
      accum_q      <= '0;
      shiftQ_q     <= '0;
      count_q      <= '0;
      divisorReg_q <= '0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      divZero_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      accum_q      <= accum_d;
      shiftQ_q     <= shiftQ_d;
      count_q      <= count_d;
      divisorReg_q <= divisorReg_d;
      quotient_q   <= quotient_d;
      remainder_q  <= remainder_d;
      divZero_q    <= divZero_d;
      done_q       <= done_d;
    end
  end

  assign bus.busy        = busyOut;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = divZero_q;

endmodule
